// File: rtl/max_unpool_2.sv
`default_nettype none
// ============================================================================
// Module   : max_unpool_2
// Purpose  : 2x2 max-unpool stage for the backward/upsampling CNN path.
//            Accepts one pooled signed fixed-point word plus the 2-bit argmax
//            position of its window, then emits the four window elements one
//            per cycle: the pooled value at the argmax position, zero at the
//            other three.
// Ports    : clk, rst_n                  clock / asynchronous active-low reset
//            in_valid, in_ready          pooled-word handshake
//            in_value [W-1:0]            pooled value (signed fixed point)
//            in_idx   [1:0]              argmax position (0 = MSB slice)
//            out_valid, out_ready        element handshake
//            out_data [W-1:0]            window element value
//            out_pos  [1:0]              window position of out_data
//            out_last                    high on position 3
//            out_window [4W-1:0]         (MAX_UNPOOL_PACKED_EN) packed window
//            out_window_valid            (MAX_UNPOOL_PACKED_EN) one-cycle pulse
// Options  : `define MAX_UNPOOL_PACKED_EN adds the registered packed-window
//            outputs; the serial behaviour is the same either way.
// Revision : 1.0  initial release
// ============================================================================
module max_unpool_2 #(
  parameter  int INTEGER_BITS     = 9,
  parameter  int FIXED_POINT_BITS = 4,
  localparam int W                = INTEGER_BITS + FIXED_POINT_BITS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_value,
  input  logic [1:0]     in_idx,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [1:0]     out_pos,
  output logic           out_last
`ifdef MAX_UNPOOL_PACKED_EN
  ,
  output logic [4*W-1:0] out_window,
  output logic           out_window_valid
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state, state_nxt;
  logic [1:0]   cnt, cnt_nxt;
  logic [W-1:0] value_q, value_nxt;
  logic [1:0]   idx_q, idx_nxt;

  logic         accept;
  logic         out_xfer;

  assign accept   = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // State and window registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 2'd0;
      value_q <= '0;
      idx_q   <= 2'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      value_q <= value_nxt;
      idx_q   <= idx_nxt;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    value_nxt = value_q;
    idx_nxt   = idx_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_pos   = 2'd0;
    out_last  = 1'b0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          value_nxt = in_value;
          idx_nxt   = in_idx;
          cnt_nxt   = 2'd0;
          state_nxt = EMIT;
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        out_pos   = cnt;
        out_data  = (cnt == idx_q) ? value_q : '0;
        out_last  = (cnt == 2'd3);
        // The next word may only enter while the last element leaves, so the
        // window stream stays gap-free without a second buffer.
        in_ready  = (cnt == 2'd3) && out_ready;
        if (out_xfer) begin
          if (cnt != 2'd3) begin
            cnt_nxt = cnt + 2'd1;
          end else if (accept) begin
            value_nxt = in_value;
            idx_nxt   = in_idx;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt   = 2'd0;
            state_nxt = IDLE;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef MAX_UNPOOL_PACKED_EN
  logic [4*W-1:0] window_nxt;

  // Element k sits at slice (3-k): element 0 occupies the MSBs.
  always_comb begin
    window_nxt = '0;
    for (int k = 0; k < 4; k++) begin
      if (in_idx == 2'(k)) begin
        window_nxt[(3-k)*W +: W] = in_value;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_window       <= '0;
      out_window_valid <= 1'b0;
    end else begin
      out_window_valid <= accept;
      if (accept) begin
        out_window <= window_nxt;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/max_unpool_2.md
Name: max_unpool_2

Overview:
- Reverse-direction companion of the 2x2 max-pool stage. Used on the backward/upsampling path of the CNN datapath.
- Takes one pooled value plus the 2-bit argmax position of its 2x2 window.
- Expands it back into the four window elements, serialised one per cycle: the value goes to the argmax position, fixed-point zero to the other three.
- Same signed two's-complement fixed-point format as the pooling stage.

Parameters:
- INTEGER_BITS, 9, integer bits of the fixed-point word (includes sign).
- FIXED_POINT_BITS, 4, fractional bits.
- W (localparam) = INTEGER_BITS+FIXED_POINT_BITS, word width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  pooled word offered.
- in_ready  out  1  block accepts the pooled word this cycle.
- in_value  in  W  pooled value, signed fixed point.
- in_idx  in  2  argmax position 0..3. Element 0 is the window element packed at the MSB slice of the pooling input; 3 is the LSB slice.
- out_valid  out  1  window element present.
- out_ready  in  1  downstream accepts element.
- out_data  out  W  window element value.
- out_pos  out  2  window position of out_data (0..3).
- out_last  out  1  high on position 3 of each window.

Behaviour:
- Reset is asynchronous on rst_n low.
  - State goes to IDLE; cnt, value and idx registers go to 0.
  - out_valid=0, out_data=0, out_pos=0, out_last=0.
  - in_ready=1 combinationally from IDLE.
- Handshakes:
  - Input transfer when in_valid&&in_ready. Output transfer when out_valid&&out_ready.
  - Data is sampled only on a transfer. in_value/in_idx changes while not accepted are ignored.
- FSM with 2 states:
  - IDLE: in_ready=1, out_valid=0. On accept, latch in_value and in_idx, set cnt=0, go to EMIT.
  - EMIT: out_valid=1, out_pos=cnt.
    - out_data=(cnt==idx_q)?value_q:0 (all W bits zero).
    - out_last=(cnt==3).
    - On output transfer with cnt<3: cnt+1.
    - On output transfer with cnt==3: if an input transfer happens the same cycle, latch it, set cnt=0 and stay in EMIT; else go to IDLE.
- in_ready = IDLE || (EMIT && cnt==3 && out_ready). This is the only combinational out_ready->in_ready path.
- Latency: first element is valid the cycle after accept. Throughput is 4 cycles per pooled word with back-to-back input and no stalls.
- Stall: while out_valid&&!out_ready, out_data/out_pos/out_last are held stable; cnt does not advance.
- Arithmetic: no arithmetic. value_q is passed bit-exact, sign preserved; the most-negative code 1<<(W-1) passes unchanged.
- Reset mid-window: the window is discarded; no further elements from it are emitted after rst_n rises.
- Exactly one element per window carries value_q; a value_q of 0 yields four zero elements (legal).

Optional Feature:
- Macro MAX_UNPOOL_PACKED_EN.
- Defined: adds two outputs.
  - out_window (4*W): registered packed window, element 0 at bits [4W-1:3W], element 3 at [W-1:0], same packing as the pooling input.
  - out_window_valid (1): one-cycle pulse the cycle after the accept, alongside the first serial element.
  - out_window holds until the next accept; both reset to 0.
- Not defined: ports absent; serial behaviour identical.

Test Plan:
- Reset then in_value=13'h0123, in_idx=2, out_ready=1 -> elements pos0..3 = 0,0,13'h0123,0 on 4 consecutive cycles; out_last only on pos3; in_ready low during cnt 0..2.
- in_value=13'h1FF0 (-1.0), idx=0 -> pos0=13'h1FF0, pos1..3=0; sign preserved.
- Same as first case with out_ready low for 3 cycles at pos1 -> out_data=0, out_pos=1 held stable; sequence resumes unchanged.
- Two words back-to-back (13'h0010 idx3, 13'h0020 idx1), in_valid held, out_ready=1 -> 8 consecutive valid cycles, no gaps; second accept on the pos3 cycle of the first.
- rst_n pulsed low at pos1 of a window -> out_valid=0 immediately; after release in_ready=1, no residual elements.
- With MAX_UNPOOL_PACKED_EN: 13'h0ABC idx1 -> out_window=={13'h0,13'h0ABC,13'h0,13'h0}, single-cycle out_window_valid pulse.
